// File: rtl/mul_err_pkg.sv
// mul_err_pkg: shared types, constants and the error-distance helper for mul_err_accum
package mul_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } err_state_t;

    // Cycles spent flushing the datapath after the last accepted sample
    localparam int DRAIN_CYCLES = 2;

    // Widest product the helper handles; callers zero-extend into this width
    localparam int ED_MAX_W = 32;

    typedef struct packed {
        logic                over;
        logic [ED_MAX_W-1:0] ed;
    } ed_res_t;

    // Absolute difference between exact and approximate products plus overestimate flag
    function automatic ed_res_t ed_abs(input logic [ED_MAX_W-1:0] exact,
                                       input logic [ED_MAX_W-1:0] approx);
        ed_res_t r;
        r.over = approx > exact;
        r.ed   = r.over ? approx - exact : exact - approx;
        return r;
    endfunction

endpackage

// File: rtl/mul_err_dist.sv
// mul_err_dist: operand capture, exact multiply and error-distance pipeline stages
module mul_err_dist
    import mul_err_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_in1,
    input  logic [WIDTH-1:0]   i_in2,
    input  logic [2*WIDTH-1:0] i_approx,
    output logic               o_valid,
    output logic [2*WIDTH-1:0] o_ed,
    output logic               o_over
);

    localparam int PW = 2 * WIDTH;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_in1;
    logic [WIDTH-1:0] r_s1_in2;
    logic [PW-1:0]    r_s1_approx;
    logic             r_s2_valid;
    logic [PW-1:0]    r_s2_ed;
    logic             r_s2_over;

    logic [PW-1:0]    w_exact;
    ed_res_t          w_res;
    logic             w_unused_hi;

    assign w_exact     = PW'(r_s1_in1) * PW'(r_s1_in2);
    assign w_res       = ed_abs(ED_MAX_W'(w_exact), ED_MAX_W'(r_s1_approx));
    assign w_unused_hi = ^w_res.ed[ED_MAX_W-1:PW];

    // S1: capture the accepted operand pair and its approximate product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_in1    <= '0;
            r_s1_in2    <= '0;
            r_s1_approx <= '0;
        end else begin
            r_s1_valid  <= i_valid;
            r_s1_in1    <= i_in1;
            r_s1_in2    <= i_in2;
            r_s1_approx <= i_approx;
        end
    end

    // S2: register error distance and overestimate flag against the exact product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_ed    <= '0;
            r_s2_over  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_ed    <= w_res.ed[PW-1:0];
            r_s2_over  <= w_res.over;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_ed    = r_s2_ed;
    assign o_over  = r_s2_over;

endmodule

// File: rtl/mul_err_accum.sv
// mul_err_accum: windowed error statistics for an approximate multiplier
module mul_err_accum
    import mul_err_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_num_samples,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_in1,
    input  logic [WIDTH-1:0]   i_in2,
    input  logic [2*WIDTH-1:0] i_approx,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_n_samples,
    output logic [CNT_W-1:0]   o_n_err,
    output logic [CNT_W-1:0]   o_n_over,
    output logic [ACC_W-1:0]   o_sum_ed,
    output logic [2*WIDTH-1:0] o_max_ed,
    output logic               o_sum_sat
);

    localparam int             PW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0]     DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    err_state_t       r_state;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [1:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_n_samples;
    logic [CNT_W-1:0] r_n_err;
    logic [CNT_W-1:0] r_n_over;
    logic [ACC_W-1:0] r_sum_ed;
    logic [PW-1:0]    r_max_ed;
    logic             r_sum_sat;

    logic             w_accept;
    logic             w_start_ok;
    logic             w_s2_valid;
    logic [PW-1:0]    w_ed;
    logic             w_over;
    logic [ACC_W:0]   w_sum_ext;
    logic             w_carry;

    assign o_in_ready = (r_state == RUN) && (r_acc_cnt != r_target);
    assign o_busy     = (r_state == RUN) || (r_state == DRAIN);
    assign o_done     = (r_state == DONE);
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_sum_ext  = {1'b0, r_sum_ed} + (ACC_W + 1)'(w_ed);
    assign w_carry    = w_sum_ext[ACC_W];

    mul_err_dist #(.WIDTH(WIDTH)) u_dist (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (w_accept),
        .i_in1    (i_in1),
        .i_in2    (i_in2),
        .i_approx (i_approx),
        .o_valid  (w_s2_valid),
        .o_ed     (w_ed),
        .o_over   (w_over)
    );

    // Window control: accept target samples, drain the datapath, then hold DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_target    <= '0;
            r_acc_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_target  <= i_num_samples;
                        r_acc_cnt <= '0;
                        r_state   <= (i_num_samples == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (w_accept)
                        r_acc_cnt <= r_acc_cnt + CNT_ONE;
                    if (r_acc_cnt == r_target) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                    if (r_drain_cnt == DRAIN_LAST)
                        r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // S3: clear on a new window, otherwise fold each valid error distance into the totals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_samples <= '0;
            r_n_err     <= '0;
            r_n_over    <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
            r_sum_sat   <= 1'b0;
        end else if (w_start_ok) begin
            r_n_samples <= '0;
            r_n_err     <= '0;
            r_n_over    <= '0;
            r_sum_ed    <= '0;
            r_max_ed    <= '0;
            r_sum_sat   <= 1'b0;
        end else if (w_s2_valid) begin
            r_n_samples <= r_n_samples + CNT_ONE;
            if (w_ed != '0)
                r_n_err <= r_n_err + CNT_ONE;
            if (w_over)
                r_n_over <= r_n_over + CNT_ONE;
            r_sum_ed  <= w_carry ? '1 : w_sum_ext[ACC_W-1:0];
            r_sum_sat <= r_sum_sat | w_carry;
            if (w_ed > r_max_ed)
                r_max_ed <= w_ed;
        end
    end

    assign o_n_samples = r_n_samples;
    assign o_n_err     = r_n_err;
    assign o_n_over    = r_n_over;
    assign o_sum_ed    = r_sum_ed;
    assign o_max_ed    = r_max_ed;
    assign o_sum_sat   = r_sum_sat;

endmodule

// File: tb/tb_mul_err_accum.sv
// tb_mul_err_accum: directed scoreboard bench for mul_err_accum
module tb_mul_err_accum;

    localparam int W   = 6;
    localparam int CW  = 16;
    localparam int AW  = 32;
    localparam int AWS = 12;
    localparam int PW  = 2 * W;

    typedef struct {
        longint n;
        longint err;
        longint over;
        longint sum;
        longint mx;
        longint sat;
    } sum_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, start_s, in_valid;
    logic [CW-1:0] num;
    logic [W-1:0]  a, b;
    logic [PW-1:0] ap;

    logic          in_ready, busy, done, sum_sat;
    logic [CW-1:0] n_samples, n_err, n_over;
    logic [AW-1:0] sum_ed;
    logic [PW-1:0] max_ed;

    logic           s_in_ready, s_busy, s_done, s_sum_sat;
    logic [CW-1:0]  s_n_samples, s_n_err, s_n_over;
    logic [AWS-1:0] s_sum_ed;
    logic [PW-1:0]  s_max_ed;

    sum_t   exp_q[$];
    longint m_n, m_err, m_over, m_sum, m_mx, m_sat;
    int     n_tests = 0;
    int     n_fail = 0;
    bit     acc;
    int     n_acc;

    mul_err_accum #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_num_samples(num),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in1(a), .i_in2(b), .i_approx(ap),
        .o_busy(busy), .o_done(done), .o_n_samples(n_samples), .o_n_err(n_err),
        .o_n_over(n_over), .o_sum_ed(sum_ed), .o_max_ed(max_ed), .o_sum_sat(sum_sat)
    );

    mul_err_accum #(.WIDTH(W), .CNT_W(CW), .ACC_W(AWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_start(start_s), .i_num_samples(num),
        .i_in_valid(in_valid), .o_in_ready(s_in_ready), .i_in1(a), .i_in2(b), .i_approx(ap),
        .o_busy(s_busy), .o_done(s_done), .o_n_samples(s_n_samples), .o_n_err(s_n_err),
        .o_n_over(s_n_over), .o_sum_ed(s_sum_ed), .o_max_ed(s_max_ed), .o_sum_sat(s_sum_sat)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_n = 0; m_err = 0; m_over = 0; m_sum = 0; m_mx = 0; m_sat = 0;
    endtask

    task automatic model_add(input longint x, input longint y, input longint z, input int aw);
        longint exact, ed, lim;
        exact = x * y;
        ed    = (z > exact) ? z - exact : exact - z;
        lim   = (longint'(1) << aw) - 1;
        m_n++;
        if (ed != 0) m_err++;
        if (z > exact) m_over++;
        m_sum += ed;
        if (m_sum > lim) begin
            m_sum = lim;
            m_sat = 1;
        end
        if (ed > m_mx) m_mx = ed;
    endtask

    task automatic push_exp();
        sum_t e;
        e = '{m_n, m_err, m_over, m_sum, m_mx, m_sat};
        exp_q.push_back(e);
    endtask

    task automatic send(input logic v, input int x, input int y, input int z,
                        input bit sat_dut, output bit accepted);
        in_valid = v;
        a  = W'(x);
        b  = W'(y);
        ap = PW'(z);
        accepted = v && (sat_dut ? s_in_ready : in_ready);
        if (accepted) model_add(x, y, z, sat_dut ? AWS : AW);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input bit sat_dut, input int n);
        num = CW'(n);
        if (sat_dut) start_s = 1'b1; else start = 1'b1;
        model_clear();
        @(posedge clk); #1;
        start   = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic wait_done(input bit sat_dut, input int exp_lat, input string tag);
        int   c;
        sum_t e;
        c = 0;
        while (!(sat_dut ? s_done : done) && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_done"}, sat_dut ? s_done : done, 1);
        if (exp_lat >= 0) chk({tag, "_latency"}, c, exp_lat);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_n_samples"}, sat_dut ? s_n_samples : n_samples, e.n);
            chk({tag, "_n_err"},     sat_dut ? s_n_err : n_err, e.err);
            chk({tag, "_n_over"},    sat_dut ? s_n_over : n_over, e.over);
            chk({tag, "_sum_ed"},    sat_dut ? longint'(s_sum_ed) : longint'(sum_ed), e.sum);
            chk({tag, "_max_ed"},    sat_dut ? s_max_ed : max_ed, e.mx);
            chk({tag, "_sum_sat"},   sat_dut ? s_sum_sat : sum_sat, e.sat);
        end
    endtask

    initial begin
        start = 1'b0; start_s = 1'b0; in_valid = 1'b0; num = '0;
        a = '0; b = '0; ap = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_n_samples", n_samples, 0);
        chk("rst_n_err", n_err, 0);
        chk("rst_sum_ed", sum_ed, 0);
        chk("rst_max_ed", max_ed, 0);
        chk("rst_sum_sat", sum_sat, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single exact sample
        do_start(0, 1);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready", in_ready, 1);
        send(1, 63, 63, 3969, 0, acc);
        chk("t1_accept", acc, 1);
        push_exp();
        wait_done(0, 3, "t1");

        // three back-to-back samples
        do_start(0, 3);
        send(1, 63, 63, 3900, 0, acc); chk("t2_acc0", acc, 1);
        send(1, 10, 12, 124, 0, acc);  chk("t2_acc1", acc, 1);
        send(1, 5, 5, 25, 0, acc);     chk("t2_acc2", acc, 1);
        push_exp();
        wait_done(0, 3, "t2");
        chk("t2_sum_const", sum_ed, 73);
        chk("t2_max_const", max_ed, 69);

        // toggling valid, extra pulses after the window is full
        do_start(0, 2);
        n_acc = 0;
        send(1, 7, 9, 60, 0, acc);  n_acc += int'(acc);
        send(0, 3, 3, 0, 0, acc);   n_acc += int'(acc);
        send(1, 1, 1, 1, 0, acc);   n_acc += int'(acc);
        chk("t3_ready_low", in_ready, 0);
        send(1, 2, 2, 100, 0, acc); n_acc += int'(acc);
        send(1, 4, 4, 0, 0, acc);   n_acc += int'(acc);
        chk("t3_accepts", n_acc, 2);
        push_exp();
        wait_done(0, -1, "t3");

        // zero-length window
        num = '0;
        start = 1'b1;
        model_clear();
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_busy", busy, 0);
        push_exp();
        wait_done(0, 0, "t4");

        // start during RUN is ignored
        do_start(0, 2);
        num = CW'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_busy", busy, 1);
        send(1, 9, 9, 90, 0, acc);  chk("t5_acc0", acc, 1);
        send(1, 6, 7, 40, 0, acc);  chk("t5_acc1", acc, 1);
        chk("t5_ready_low", in_ready, 0);
        push_exp();
        wait_done(0, 3, "t5");

        // saturation on the narrow accumulator
        do_start(1, 3);
        repeat (3) begin
            send(1, 0, 0, 4095, 1, acc);
            chk("t6_acc", acc, 1);
        end
        push_exp();
        wait_done(1, 3, "t6");
        chk("t6_sum_const", s_sum_ed, 4095);
        chk("t6_sat_const", s_sum_sat, 1);

        // reset aborts an open window
        do_start(0, 4);
        send(1, 63, 1, 0, 0, acc);  chk("t7_acc0", acc, 1);
        send(1, 2, 3, 10, 0, acc);  chk("t7_acc1", acc, 1);
        send(0, 0, 0, 0, 0, acc);
        chk("t7_pre_sum", sum_ed, 63);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_in_ready", in_ready, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_n_samples", n_samples, 0);
        chk("t7_rst_n_err", n_err, 0);
        chk("t7_rst_sum_ed", sum_ed, 0);
        chk("t7_rst_max_ed", max_ed, 0);
        chk("t7_rst_s_sum_ed", s_sum_ed, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(0, 1);
        send(1, 3, 3, 8, 0, acc);
        chk("t8_acc", acc, 1);
        push_exp();
        wait_done(0, 3, "t8");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
